// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, event type codes and serialiser FSM states.
// Used by both the transmit serialiser and the receive parser.
package midi_pkg;

  localparam logic [3:0] S_NOTE_OFF = 4'h8;
  localparam logic [3:0] S_NOTE_ON  = 4'h9;
  localparam logic [3:0] S_CC       = 4'hB;
  localparam logic [3:0] S_PROG     = 4'hC;

  typedef enum logic [1:0] {
    EV_NOTE_OFF = 2'd0,
    EV_NOTE_ON  = 2'd1,
    EV_CC       = 2'd2,
    EV_PROG     = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SEND_STATUS = 2'd1,
    ST_SEND_D1     = 2'd2,
    ST_SEND_D2     = 2'd3
  } tx_state_e;

  function automatic logic [3:0] status_nibble(input logic [1:0] ev_type);
    logic [3:0] nib;
    case (ev_type)
      EV_NOTE_OFF: nib = S_NOTE_OFF;
      EV_NOTE_ON:  nib = S_NOTE_ON;
      EV_CC:       nib = S_CC;
      default:     nib = S_PROG;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/register_clr.sv
// Enable register with synchronous clear; clear has priority over load.
module register_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI channel-voice event serialiser: status byte (optionally running-status
// compressed) followed by one or two data bytes, handed to a UART one byte at a time.
module midi_tx
  import midi_pkg::*;
#(
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] channel,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [1:0] ev_type,
  input  logic [6:0] ev_d1,
  input  logic [6:0] ev_d2,
  output logic [7:0] tx_data,
  output logic       tx_dv,
  input  logic       tx_ready,
  output logic       busy
);

  tx_state_e  state_reg, state_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic       accept, status_xfer, xfer, skip_status;
  logic [7:0] status_in, status_q, last_status_q;
  logic [6:0] d1_q, d2_q;
  logic       last_valid_q;

  assign status_in   = {status_nibble(ev_type), channel};
  assign skip_status = (RUNNING_STATUS != 0) && last_valid_q && (status_in == last_status_q);

  register_clr #(.W(8)) u_status (.clk(clk), .clr(rst), .en(accept), .d(status_in), .q(status_q));
  register_clr #(.W(7)) u_d1     (.clk(clk), .clr(rst), .en(accept), .d(ev_d1),     .q(d1_q));
  register_clr #(.W(7)) u_d2     (.clk(clk), .clr(rst), .en(accept), .d(ev_d2),     .q(d2_q));

  // Only a status byte that actually went out on the wire may be relied on later.
  register_clr #(.W(8)) u_last_status (.clk(clk), .clr(rst), .en(status_xfer), .d(status_q), .q(last_status_q));
  register_clr #(.W(1)) u_last_valid  (.clk(clk), .clr(rst), .en(status_xfer), .d(1'b1),     .q(last_valid_q));

  assign ev_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg != ST_IDLE);
  assign tx_dv    = (state_reg != ST_IDLE);
  assign tx_data  = tx_data_reg;
  assign xfer     = tx_dv & tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      tx_data_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      tx_data_reg <= tx_data_next;
    end
  end

  // The byte for the next state is loaded on the same edge as the state change,
  // so tx_data is registered and only moves when a transfer completes.
  always_comb begin
    state_next   = state_reg;
    tx_data_next = tx_data_reg;
    accept       = 1'b0;
    status_xfer  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ev_valid) begin
          accept = 1'b1;
          if (skip_status) begin
            state_next   = ST_SEND_D1;
            tx_data_next = {1'b0, ev_d1};
          end else begin
            state_next   = ST_SEND_STATUS;
            tx_data_next = status_in;
          end
        end
      end
      ST_SEND_STATUS: begin
        if (xfer) begin
          status_xfer  = 1'b1;
          state_next   = ST_SEND_D1;
          tx_data_next = {1'b0, d1_q};
        end
      end
      ST_SEND_D1: begin
        if (xfer) begin
          if (status_q[7:4] == S_PROG) begin
            state_next   = ST_IDLE;
            tx_data_next = 8'h00;
          end else begin
            state_next   = ST_SEND_D2;
            tx_data_next = {1'b0, d2_q};
          end
        end
      end
      ST_SEND_D2: begin
        if (xfer) begin
          state_next   = ST_IDLE;
          tx_data_next = 8'h00;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        tx_data_next = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: hand-computed byte streams, backpressure, mid-message
// reset and a short randomised run against a running-status reference model.
module tb_midi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] channel;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_type;
  logic [6:0] ev_d1;
  logic [6:0] ev_d2;
  logic [7:0] tx_data;
  logic       tx_dv;
  logic       tx_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_last;
  logic       m_valid;

  midi_tx #(.RUNNING_STATUS(1)) dut (
    .clk(clk), .rst(rst), .channel(channel), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_type(ev_type), .ev_d1(ev_d1), .ev_d2(ev_d2), .tx_data(tx_data), .tx_dv(tx_dv),
    .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the accepting edge.
  task automatic start_event(input logic [1:0] t, input logic [3:0] c,
                             input logic [6:0] d1, input logic [6:0] d2);
    ev_type  = t;
    channel  = c;
    ev_d1    = d1;
    ev_d2    = d2;
    ev_valid = 1'b1;
    chk("accept_ready", 32'(ev_ready), 32'd1);
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  // Holds tx_ready low for 'stall' cycles (byte must stay put), then lets it go.
  task automatic check_byte(input string tag, input logic [7:0] exp, input int stall);
    tx_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_hold_dv"}, 32'(tx_dv), 32'd1);
      chk({tag, "_hold"}, 32'(tx_data), 32'(exp));
      @(negedge clk);
    end
    tx_ready = 1'b1;
    chk({tag, "_dv"}, 32'(tx_dv), 32'd1);
    chk(tag, 32'(tx_data), 32'(exp));
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ev_ready"}, 32'(ev_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tx_dv"}, 32'(tx_dv), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] st;
    logic [1:0] rt;
    logic [3:0] rc;
    logic [6:0] r1, r2;

    rst = 1'b1; ev_valid = 1'b0; ev_type = 2'd0; channel = 4'd0;
    ev_d1 = 7'd0; ev_d2 = 7'd0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    check_idle("rst");

    // Note on ch0 60/100: full three-byte message, one byte per cycle.
    start_event(2'd1, 4'd0, 7'd60, 7'd100);
    chk("non_busy", 32'(busy), 32'd1);
    chk("non_ev_ready_low", 32'(ev_ready), 32'd0);
    check_byte("non_status", 8'h90, 0);
    check_byte("non_d1", 8'h3C, 0);
    check_byte("non_d2", 8'h64, 0);
    check_idle("non_done");

    // Same status again: running status drops the status byte.
    start_event(2'd1, 4'd0, 7'd62, 7'd64);
    check_byte("rs_d1", 8'h3E, 0);
    check_byte("rs_d2", 8'h40, 0);
    check_idle("rs_done");

    start_event(2'd2, 4'd0, 7'd7, 7'd127);
    check_byte("cc_status", 8'hB0, 0);
    check_byte("cc_d1", 8'h07, 0);
    check_byte("cc_d2", 8'h7F, 0);
    check_idle("cc_done");

    // Program change: two bytes only, ev_d2 must not appear.
    start_event(2'd3, 4'd5, 7'd10, 7'd99);
    check_byte("pc_status", 8'hC5, 0);
    check_byte("pc_d1", 8'h0A, 0);
    check_idle("pc_done");

    // Backpressure in SEND_D1 for 5 cycles, with a competing request that must be ignored.
    start_event(2'd0, 4'd1, 7'd33, 7'd44);
    check_byte("bp_status", 8'h81, 0);
    tx_ready = 1'b0;
    ev_type = 2'd3; channel = 4'd2; ev_d1 = 7'd1; ev_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_dv", 32'(tx_dv), 32'd1);
      chk("bp_hold_data", 32'(tx_data), 32'h21);
      chk("bp_ev_ready_low", 32'(ev_ready), 32'd0);
      @(negedge clk);
    end
    ev_valid = 1'b0;
    check_byte("bp_d1", 8'h21, 0);
    check_byte("bp_d2", 8'h2C, 0);
    check_idle("bp_done");
    @(negedge clk);
    check_idle("idle_tx_ready_no_effect");

    // Reset during SEND_D1 aborts; next note on resends the full status.
    start_event(2'd1, 4'd0, 7'd60, 7'd100);
    check_byte("ab_status", 8'h90, 0);
    chk("ab_d1_present", 32'(tx_data), 32'h3C);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_tx_dv", 32'(tx_dv), 32'd0);
    chk("ab_tx_data", 32'(tx_data), 32'h00);
    chk("ab_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start_event(2'd1, 4'd0, 7'd60, 7'd100);
    check_byte("ab2_status", 8'h90, 0);
    check_byte("ab2_d1", 8'h3C, 0);
    check_byte("ab2_d2", 8'h64, 0);
    check_idle("ab2_done");

    // Note on with velocity 0 goes out unchanged (running status still 0x90).
    start_event(2'd1, 4'd0, 7'd60, 7'd0);
    check_byte("v0_d1", 8'h3C, 0);
    check_byte("v0_d2", 8'h00, 0);
    check_idle("v0_done");

    // Randomised events with random stalls against a reference model.
    m_last = 8'h90;
    m_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rt = 2'($urandom_range(0, 3));
      rc = 4'($urandom_range(0, 1));
      r1 = 7'($urandom_range(0, 127));
      r2 = 7'($urandom_range(0, 127));
      case (rt)
        2'd0: st = {4'h8, rc};
        2'd1: st = {4'h9, rc};
        2'd2: st = {4'hB, rc};
        default: st = {4'hC, rc};
      endcase
      exp_q.delete();
      if (!(m_valid && st == m_last)) begin
        exp_q.push_back(st);
        m_last = st;
        m_valid = 1'b1;
      end
      exp_q.push_back({1'b0, r1});
      if (rt != 2'd3) exp_q.push_back({1'b0, r2});
      start_event(rt, rc, r1, r2);
      foreach (exp_q[k]) check_byte("rnd_byte", exp_q[k], int'($urandom_range(0, 2)));
      check_idle("rnd_done");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
